// File: rtl/bsg_arb_client_launch.sv
// ---------------------------------------------------------------------------
// bsg_arb_client_launch
//
// Requester-side companion to a fixed-priority arbiter. Each client parks one
// word in a private 1-entry hold register. Valid holds are presented to the
// arbiter as requests. The arbiter returns a one-hot grant in the same cycle.
// The granted word and its client index move into a 2-entry output FIFO that
// drains through a valid/yumi handshake. Illegal grants and illegal yumi are
// ignored and latched into a sticky error flag.
//
// Ports
//   clk_i        clock, rising edge
//   reset_n_i    asynchronous active-low reset
//   v_i          per-client word valid
//   data_i       client words, client k at [k*width_p +: width_p]
//   ready_o      per-client accept (v_i & ready_o = transfer)
//   reqs_o       request vector to the arbiter (registered hold valids)
//   arb_ready_o  output FIFO can take a word this cycle (to arbiter ready_i)
//   grants_i     one-hot grant returned by the arbiter
//   v_o          output FIFO head valid
//   data_o       head word
//   id_o         client index of the head word
//   yumi_i       downstream consumes the head; legal only while v_o=1
//   err_o        sticky protocol-error flag
// ---------------------------------------------------------------------------
module bsg_arb_client_launch #(
    parameter int inputs_p   = 16,
    parameter int width_p    = 32,
    parameter int id_width_p = $clog2(inputs_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [inputs_p-1:0]         v_i,
    input  logic [inputs_p*width_p-1:0] data_i,
    output logic [inputs_p-1:0]         ready_o,
    output logic [inputs_p-1:0]         reqs_o,
    output logic                        arb_ready_o,
    input  logic [inputs_p-1:0]         grants_i,
    output logic                        v_o,
    output logic [width_p-1:0]          data_o,
    output logic [id_width_p-1:0]       id_o,
    input  logic                        yumi_i,
    output logic                        err_o
);

    logic [inputs_p-1:0]   hold_v;
    logic [width_p-1:0]    hold_data [inputs_p];

    logic [1:0]            count;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [width_p-1:0]    fifo_data [2];
    logic [id_width_p-1:0] fifo_id   [2];

    logic                  grant_any;
    logic                  grant_onehot;
    logic                  grant_stray;
    logic                  gnt_ok;
    logic [inputs_p-1:0]   take;
    logic [inputs_p-1:0]   load;
    logic [id_width_p-1:0] grant_idx;
    logic                  enq;
    logic                  deq;
    logic                  yumi_bad;

    // Grant legality: exactly one bit, only on a requesting client, and only
    // while the FIFO has room. Anything else is dropped entirely.
    assign grant_any    = |grants_i;
    assign grant_onehot = grant_any &&
                          ((grants_i & (grants_i - inputs_p'(1))) == '0);
    assign grant_stray  = |(grants_i & ~hold_v);
    assign gnt_ok       = grant_onehot & ~grant_stray & arb_ready_o;

    assign take    = gnt_ok ? grants_i : '0;
    // A hold being drained this cycle can be refilled on the same edge,
    // which is what gives a winning client one word per cycle.
    assign ready_o = ~hold_v | take;
    assign load    = v_i & ready_o;
    assign reqs_o  = hold_v;

    assign arb_ready_o = (count != 2'd2);
    assign v_o         = (count != 2'd0);
    assign data_o      = fifo_data[rd_ptr];
    assign id_o        = fifo_id[rd_ptr];

    assign enq      = |take;
    assign deq      = yumi_i & v_o;
    assign yumi_bad = yumi_i & ~v_o;

    // Binary index of the grant bit; only meaningful when the grant is legal.
    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < inputs_p; k++) begin
            if (grants_i[k]) begin
                grant_idx = id_width_p'(k);
            end
        end
    end

    // Hold valids: a new load wins over a drain of the same slot.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hold_v <= '0;
        end else begin
            hold_v <= (hold_v & ~take) | load;
        end
    end

    // Hold data is plain storage, qualified everywhere by hold_v.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < inputs_p; k++) begin
            if (load[k]) begin
                hold_data[k] <= data_i[k*width_p +: width_p];
            end
        end
    end

    // FIFO control. enq is already blocked when full (gnt_ok needs
    // arb_ready_o) and deq is already blocked when empty (needs v_o).
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            if (enq && !deq) begin
                count <= count + 2'd1;
            end else if (deq && !enq) begin
                count <= count - 2'd1;
            end
        end
    end

    // FIFO storage, qualified by count.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            fifo_data[wr_ptr] <= hold_data[grant_idx];
            fifo_id[wr_ptr]   <= grant_idx;
        end
    end

    // Sticky protocol error.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_o <= 1'b0;
        end else if ((grant_any & ~arb_ready_o) | (grant_any & ~grant_onehot) |
                     grant_stray | yumi_bad) begin
            err_o <= 1'b1;
        end
    end

endmodule
